if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
- Instruction-fetch sequencer between the PC register unit and the instruction cache.
- Issues one cache request at a time for the current PC and pushes each returned instruction with its PC into a small in-order queue that feeds decode.
- Pulses the PC-advance enable once per accepted instruction.
- Flushes the queue and discards any in-flight response on a commit redirect.

Parameters:
ADDR_WIDTH, 32, PC/address width
INSTR_WIDTH, 32, instruction width
QUEUE_DEPTH, 8, instruction queue entries (power of 2, >=2)
QPTR_WIDTH, 3, log2(QUEUE_DEPTH)

Ports:
clk_in  input  1  clock; all logic on posedge
rst_in  input  1  synchronous, active-high reset
rdy_in  input  1  global ready; when low, all state and outputs freeze
pc_in  input  ADDR_WIDTH  current PC from PC unit; valid the cycle after any advance or redirect
pc_en_out  output  1  one-cycle advance pulse to PC unit (PC+4 on next edge)
flush_in  input  1  commit redirect; same cycle the PC unit takes the new target
icache_req_out  output  1  fetch request valid
icache_addr_out  output  ADDR_WIDTH  fetch address; stable while req high
icache_ack_in  input  1  one-cycle response strobe
icache_data_in  input  INSTR_WIDTH  instruction; valid with ack
dec_valid_out  output  1  queue non-empty
dec_instr_out  output  INSTR_WIDTH  head instruction
dec_pc_out  output  ADDR_WIDTH  head PC
dec_ready_in  input  1  decode accepts head this cycle

Behaviour:
- Reset (sync, rst_in high at posedge, priority over rdy_in):
  - state=IDLE; queue empty (head=tail=count=0).
  - icache_req_out=0, icache_addr_out=0, pc_en_out=0, dec_valid_out=0.
- rdy_in low: no state, pointer or output register changes; an ack arriving then is ignored (cache also gated by rdy).
- FSM states: IDLE, WAIT, ADV, DRAIN.
- IDLE:
  - If !flush_in and count<QUEUE_DEPTH: register req=1, addr=pc_in -> WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - req and addr held stable.
  - ack && !flush_in: push {pc=addr, instr=data}, drop req, set pc_en_out=1 -> ADV.
  - flush_in (with or without ack): clear queue.
    - With ack: drop req, discard data -> IDLE.
    - Without ack: -> DRAIN.
- ADV:
  - pc_en_out high for exactly this cycle; cleared on exit -> IDLE.
  - pc_in is the advanced PC in the next cycle.
  - flush_in in ADV clears the queue; PC unit gives redirect priority over advance.
- DRAIN:
  - req and addr held until ack; no push, no pc_en.
  - On ack -> IDLE.
  - A further flush_in clears the queue again and stays in DRAIN.
- IDLE never issues in a flush cycle, so the first post-flush request uses the redirected pc_in.
- Minimum fetch period is 3 cycles (IDLE, WAIT with same-cycle ack, ADV).
- Queue:
  - Circular buffer; head/tail wrap modulo QUEUE_DEPTH; count is QPTR_WIDTH+1 bits.
  - dec_valid_out = (count!=0); dec_instr_out/dec_pc_out = entry[head] (combinational read).
  - Pop when dec_valid_out && dec_ready_in && !flush_in.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Only one request is outstanding and it is issued only when count<QUEUE_DEPTH, so a push never overflows.
  - When full, IDLE stalls until a pop frees a slot; the pop and the issue may occur in the same cycle only if count was already <QUEUE_DEPTH.
  - Pop of an empty queue: ignored.
- Flush always wins over push and pop in the same cycle; the result is an empty queue.
- Reset mid-request: request is abandoned, req drops next cycle; cache is reset by the same rst_in.

Test Plan:
1. Reset, pc_in=0x0, ack one cycle after every req, dec_ready_in=1 -> addresses 0x0,0x4,0x8 issued; pc_en_out pulses once per ack; dec_pc_out sequence 0x0,0x4,0x8 with matching instrs; fetch period 3 cycles.
2. dec_ready_in=0, DEPTH=8 -> exactly 8 pushes, then req stays low. Raise dec_ready_in for 1 cycle -> one pop, one new request. Pointer wrap checked after 20 fetches.
3. flush_in in WAIT with no ack, ack 3 cycles later with 0xDEADBEEF -> state DRAIN, queue empty, 0xDEADBEEF never pushed, no pc_en. Next request uses redirected pc_in=0x1000.
4. flush_in coincident with ack in WAIT, and separately coincident with a pop of a 3-entry queue -> count=0 next cycle, dec_valid_out=0, no pc_en_out.
5. rdy_in low for 5 cycles mid-WAIT and mid-ADV -> req, addr, pc_en_out and queue contents unchanged; sequence resumes identically when rdy_in returns high.
6. rst_in asserted in WAIT with 4 entries queued -> next cycle req=0, pc_en_out=0, dec_valid_out=0, state IDLE.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_ctrl
// Purpose  : Instruction-fetch sequencer. Issues one instruction-cache
//            request at a time for the current PC. Each returned instruction
//            is pushed, tagged with its PC, into a small in-order queue that
//            feeds decode. The PC-advance enable pulses once per accepted
//            instruction. A commit redirect empties the queue and discards
//            any response that is still in flight.
// Ports    : clk_in, rst_in (sync, active-high), rdy_in (global freeze)
//            pc_in / pc_en_out         - PC unit side
//            flush_in                  - commit redirect
//            icache_req/addr/ack/data  - instruction cache side
//            dec_valid/instr/pc/ready  - decode side (queue head)
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int QUEUE_DEPTH = 8,
    parameter int QPTR_WIDTH  = 3
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic [ADDR_WIDTH-1:0]  pc_in,
    output logic                   pc_en_out,
    input  logic                   flush_in,
    output logic                   icache_req_out,
    output logic [ADDR_WIDTH-1:0]  icache_addr_out,
    input  logic                   icache_ack_in,
    input  logic [INSTR_WIDTH-1:0] icache_data_in,
    output logic                   dec_valid_out,
    output logic [INSTR_WIDTH-1:0] dec_instr_out,
    output logic [ADDR_WIDTH-1:0]  dec_pc_out,
    input  logic                   dec_ready_in
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ADV   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [QPTR_WIDTH:0]   c_queue_depth = (QPTR_WIDTH+1)'(QUEUE_DEPTH);
    localparam logic [QPTR_WIDTH:0]   c_cnt_one     = (QPTR_WIDTH+1)'(1);
    localparam logic [QPTR_WIDTH-1:0] c_ptr_one     = QPTR_WIDTH'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_req;
    logic                    w_req_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   w_addr_nxt;
    logic                    r_pc_en;
    logic                    w_pc_en_nxt;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_not_full;

    logic [QPTR_WIDTH-1:0]   r_head;
    logic [QPTR_WIDTH-1:0]   r_tail;
    logic [QPTR_WIDTH:0]     r_count;
    logic [INSTR_WIDTH-1:0]  r_q_instr [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]   r_q_pc    [QUEUE_DEPTH];

    // A request is only issued with a free slot, and only one is ever
    // outstanding, so the eventual push can never overflow the queue.
    assign w_not_full = (r_count < c_queue_depth);

    // Flush suppresses the pop: a redirect empties the queue outright.
    assign w_pop = (r_count != '0) && dec_ready_in && !flush_in;

    // ------------------------------------------------------------------
    // Next-state / output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_pc_en_nxt = 1'b0;
        w_push      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Never issue in a flush cycle: pc_in is still the stale PC.
                if (!flush_in && w_not_full) begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = pc_in;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush_in) begin
                    if (icache_ack_in) begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        // Response still owed by the cache; swallow it later.
                        w_state_nxt = ST_DRAIN;
                    end
                end else if (icache_ack_in) begin
                    w_push      = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_pc_en_nxt = 1'b1;
                    w_state_nxt = ST_ADV;
                end
            end
            ST_ADV: begin
                // One cycle for the PC unit to step; pc_in is fresh after it.
                w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (icache_ack_in) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and queue-pointer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_pc_en <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_pc_en <= w_pc_en_nxt;

            if (flush_in) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + c_ptr_one;
                end
                if (w_pop) begin
                    r_head <= r_head + c_ptr_one;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_one;
                    2'b01:   r_count <= r_count - c_cnt_one;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && w_push) begin
            r_q_instr[r_tail] <= icache_data_in;
            r_q_pc[r_tail]    <= r_addr;
        end
    end

    assign pc_en_out       = r_pc_en;
    assign icache_req_out  = r_req;
    assign icache_addr_out = r_addr;
    assign dec_valid_out   = (r_count != '0);
    assign dec_instr_out   = r_q_instr[r_head];
    assign dec_pc_out      = r_q_pc[r_head];

endmodule
`default_nettype wire
